// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter slice: ALU mode encodings, datapath width
// and arbiter FSM state encodings.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [2:0] ALU_AND  = 3'd0;
  localparam logic [2:0] ALU_OR   = 3'd1;
  localparam logic [2:0] ALU_XOR  = 3'd2;
  localparam logic [2:0] ALU_SHCL = 3'd3;
  localparam logic [2:0] ALU_SHCR = 3'd4;
  localparam logic [2:0] ALU_NOT  = 3'd5;
  localparam logic [2:0] ALU_SUB  = 3'd6;
  localparam logic [2:0] ALU_ADD  = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester/response bundle of the ALU arbiter; master = requester side,
// slave = arbiter side.
interface alu_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) ();
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [3*NUM_REQ-1:0]     req_mode;
  logic [WIDTH*NUM_REQ-1:0] req_a;
  logic [WIDTH*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]       req_cin;
  logic [NUM_REQ-1:0]       req_csel;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [IDW-1:0]           rsp_id;
  logic [WIDTH-1:0]         rsp_data;
  logic                     rsp_carry;
  logic                     rsp_zero;

  modport master (
    output req_valid, req_mode, req_a, req_b, req_cin, req_csel, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero
  );

  modport slave (
    input  req_valid, req_mode, req_a, req_b, req_cin, req_csel, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_carry, rsp_zero
  );
endinterface

// File: rtl/ALU.sv
// Combinational ALU with active-low enable. ADD consumes carry_in so multi-word
// adds can chain; SUB is a - b with carry_out = no-borrow.
module ALU
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             enable,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] out,
  output logic             carry_out
);
  always_comb begin
    out       = '0;
    carry_out = 1'b0;
    if (!enable) begin
      case (mode)
        ALU_AND:  begin out = a & b; carry_out = carry_in; end
        ALU_OR:   begin out = a | b; carry_out = carry_in; end
        ALU_XOR:  begin out = a ^ b; carry_out = carry_in; end
        ALU_SHCL: begin out = {a[WIDTH-2:0], carry_in}; carry_out = a[WIDTH-1]; end
        ALU_SHCR: begin out = {carry_in, a[WIDTH-1:1]}; carry_out = a[0]; end
        ALU_NOT:  begin out = ~a; carry_out = carry_in; end
        ALU_SUB:  {carry_out, out} = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
        default:  {carry_out, out} = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(carry_in);
      endcase
    end
  end
endmodule

// File: rtl/alu_arbiter_rr_grant.sv
// Combinational round-robin search: first valid requester at or after ptr_i,
// wrapping at NUM_REQ.
module alu_rr_grant #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     idx_o,
  output logic               any_o
);
  logic [IDW-1:0] pos;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = ptr_i;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!any_o && valid_i[pos]) begin
        any_o        = 1'b1;
        idx_o        = pos;
        grant_o[pos] = 1'b1;
      end
      pos = (pos == IDW'(NUM_REQ - 1)) ? '0 : pos + 1'b1;
    end
  end
endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NUM_REQ requesters (IDLE/EXEC/RESP).
// ALU_ARB_CARRY_CHAIN_EN adds a stored carry per requester selectable via req_csel.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic         clk,
  input  logic         reset,
  alu_arbiter_if.slave bus
);
  logic [1:0]       state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [2:0]       mode_q, mode_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_zero_q, rsp_zero_d;
`ifdef ALU_ARB_CARRY_CHAIN_EN
  logic [NUM_REQ-1:0] carry_q, carry_d;
`else
  logic unused_csel;
  assign unused_csel = ^bus.req_csel;
`endif

  logic [NUM_REQ-1:0] grant_oh;
  logic [IDW-1:0]     grant_idx;
  logic               grant_any;
  logic [2:0]         sel_mode;
  logic [WIDTH-1:0]   sel_a, sel_b;
  logic               sel_cin;
  logic               alu_en_n;
  logic [WIDTH-1:0]   alu_out;
  logic               alu_cout;

  alu_rr_grant #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_grant (
    .valid_i(bus.req_valid),
    .ptr_i  (ptr_q),
    .grant_o(grant_oh),
    .idx_o  (grant_idx),
    .any_o  (grant_any)
  );

  ALU #(.WIDTH(WIDTH)) u_alu (
    .enable   (alu_en_n),
    .mode     (mode_q),
    .a        (a_q),
    .b        (b_q),
    .carry_in (cin_q),
    .out      (alu_out),
    .carry_out(alu_cout)
  );

  assign alu_en_n      = (state_q != ST_EXEC);
  assign bus.req_ready = (state_q == ST_IDLE) ? grant_oh : '0;
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_carry = rsp_carry_q;
  assign bus.rsp_zero  = rsp_zero_q;

  // Payload mux driven by the one-hot grant
  always_comb begin
    sel_mode = '0;
    sel_a    = '0;
    sel_b    = '0;
    sel_cin  = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_oh[k]) begin
        sel_mode = bus.req_mode[k*3 +: 3];
        sel_a    = bus.req_a[k*WIDTH +: WIDTH];
        sel_b    = bus.req_b[k*WIDTH +: WIDTH];
`ifdef ALU_ARB_CARRY_CHAIN_EN
        sel_cin  = bus.req_csel[k] ? carry_q[k] : bus.req_cin[k];
`else
        sel_cin  = bus.req_cin[k];
`endif
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    mode_d      = mode_q;
    a_d         = a_q;
    b_d         = b_q;
    cin_d       = cin_q;
    id_d        = id_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_carry_d = rsp_carry_q;
    rsp_zero_d  = rsp_zero_q;
`ifdef ALU_ARB_CARRY_CHAIN_EN
    carry_d     = carry_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (grant_any) begin
          mode_d  = sel_mode;
          a_d     = sel_a;
          b_d     = sel_b;
          cin_d   = sel_cin;
          id_d    = grant_idx;
          ptr_d   = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_id_d    = id_q;
        rsp_data_d  = alu_out;
        rsp_carry_d = alu_cout;
        rsp_zero_d  = (alu_out == '0);
`ifdef ALU_ARB_CARRY_CHAIN_EN
        carry_d[id_q] = alu_cout;
`endif
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      mode_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      id_q        <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      rsp_carry_q <= 1'b0;
      rsp_zero_q  <= 1'b0;
`ifdef ALU_ARB_CARRY_CHAIN_EN
      carry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      mode_q      <= mode_d;
      a_q         <= a_d;
      b_q         <= b_d;
      cin_q       <= cin_d;
      id_q        <= id_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_zero_q  <= rsp_zero_d;
`ifdef ALU_ARB_CARRY_CHAIN_EN
      carry_q     <= carry_d;
`endif
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a transaction-level model checked every cycle
// plus hand-computed expectations for the named scenarios.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int W = 32;
  localparam int N = 4;
`ifdef ALU_ARB_CARRY_CHAIN_EN
  localparam logic [31:0] CHAIN_EXP = 32'h1;
`else
  localparam logic [31:0] CHAIN_EXP = 32'h0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus ();
  alu_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int id; logic [31:0] data; logic carry; logic zero; } rsp_t;
  int   glog[$];
  int   gcyc[$];
  rsp_t rlog[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [32:0] ref_alu(input logic [2:0] m, input logic [31:0] a,
                                          input logic [31:0] b, input logic c);
    logic [63:0] s;
    logic [32:0] r;
    case (m)
      ALU_AND:  r = {c, a & b};
      ALU_OR:   r = {c, a | b};
      ALU_XOR:  r = {c, a ^ b};
      ALU_NOT:  r = {c, ~a};
      ALU_SHCL: r = {a[31], (a << 1) | 32'(c)};
      ALU_SHCR: r = {a[0], (a >> 1) | (32'(c) << 31)};
      ALU_SUB:  r = {a >= b, a - b};
      default: begin
        s = 64'(a) + 64'(b) + 64'(c);
        r = s[32:0];
      end
    endcase
    return r;
  endfunction

  // Transaction model: phase 0 = free, 1 = op accepted, 2 = response shown
  int          m_phase = 0;
  int          m_ptr = 0;
  logic [N-1:0] m_carry = '0;
  int          p_id = 0;
  logic [32:0] p_res = '0;
  int          m_id = 0;
  logic [31:0] m_data = '0;
  logic        m_c = 1'b0;
  logic        m_z = 1'b0;

  function automatic int first_valid();
    for (int i = 0; i < N; i++) begin
      int j = (m_ptr + i) % N;
      if (bus.req_valid[j]) return j;
    end
    return -1;
  endfunction

  initial begin
    int g;
    logic [N-1:0] er;
    logic cin;
    forever begin
      @(negedge clk);
      g = first_valid();
      if (!reset) begin
        er = '0;
        if (m_phase == 0 && g >= 0) er[g] = 1'b1;
        chk("req_ready", bus.req_ready, er);
        chk("rsp_valid", bus.rsp_valid, m_phase == 2);
        chk("rsp_id", bus.rsp_id, m_id);
        chk("rsp_data", bus.rsp_data, m_data);
        chk("rsp_carry", bus.rsp_carry, m_c);
        chk("rsp_zero", bus.rsp_zero, m_z);
      end
      if (reset) begin
        m_phase = 0; m_ptr = 0; m_carry = '0;
        m_id = 0; m_data = '0; m_c = 1'b0; m_z = 1'b0;
      end else begin
        case (m_phase)
          0: if (g >= 0) begin
            cin = bus.req_cin[g];
`ifdef ALU_ARB_CARRY_CHAIN_EN
            if (bus.req_csel[g]) cin = m_carry[g];
`endif
            p_id  = g;
            p_res = ref_alu(bus.req_mode[g*3 +: 3], bus.req_a[g*32 +: 32],
                            bus.req_b[g*32 +: 32], cin);
            m_ptr = (g + 1) % N;
            glog.push_back(g);
            gcyc.push_back(cyc);
            m_phase = 1;
          end
          1: begin
            m_id = p_id; m_data = p_res[31:0]; m_c = p_res[32];
            m_z = (p_res[31:0] == 32'h0);
`ifdef ALU_ARB_CARRY_CHAIN_EN
            m_carry[p_id] = p_res[32];
`endif
            m_phase = 2;
          end
          default: if (bus.rsp_ready) begin
            rlog.push_back('{int'(bus.rsp_id), bus.rsp_data, bus.rsp_carry, bus.rsp_zero});
            m_phase = 0;
          end
        endcase
      end
    end
  end

  task automatic set_req(input int i, input logic [2:0] m, input logic [31:0] a,
                         input logic [31:0] b, input logic c, input logic s);
    bus.req_mode[i*3 +: 3]  = m;
    bus.req_a[i*32 +: 32]   = a;
    bus.req_b[i*32 +: 32]   = b;
    bus.req_cin[i]          = c;
    bus.req_csel[i]         = s;
    bus.req_valid[i]        = 1'b1;
  endtask

  task automatic wait_grants(input int n);
    int target = glog.size() + n;
    for (int k = 0; k < 50 * n; k++) begin
      @(posedge clk);
      if (glog.size() >= target) break;
    end
    if (glog.size() < target) chk("grant_timeout", glog.size(), target);
    #1;
  endtask

  task automatic issue(input int i, input logic [2:0] m, input logic [31:0] a,
                       input logic [31:0] b, input logic c, input logic s);
    set_req(i, m, a, b, c, s);
    wait_grants(1);
    bus.req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp_valid(input string name);
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
    end
    if (k == 20) chk(name, 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    int base, t0, h, n;
    int e1[5] = '{0, 1, 2, 3, 0};
    int e2[3] = '{1, 3, 1};
    bus.req_valid = '0; bus.req_mode = '0; bus.req_a = '0; bus.req_b = '0;
    bus.req_cin = '0; bus.req_csel = '0; bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_rsp_data", bus.rsp_data, 0);
    chk("rst_rsp_id", bus.rsp_id, 0);
    @(posedge clk); #1;

    // Single ADD: overflow to zero, response two cycles after transfer
    issue(0, ALU_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    t0 = gcyc[gcyc.size()-1];
    wait_rsp_valid("add_rsp_timeout");
    chk("add_latency", cyc - t0, 2);
    chk("add_data", bus.rsp_data, 32'h0);
    chk("add_carry", bus.rsp_carry, 1);
    chk("add_zero", bus.rsp_zero, 1);
    chk("add_id", bus.rsp_id, 0);
    @(posedge clk); #1;

    // Round-robin fairness
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, ALU_ADD, 32'(i), 32'(i), 1'b0, 1'b0);
    base = glog.size();
    wait_grants(5);
    for (int i = 0; i < 5; i++) chk("rr_order_all", glog[base+i], e1[i]);
    chk("rr_spacing", gcyc[base+4] - gcyc[base+3], 3);
    bus.req_valid = 4'b1010;
    base = glog.size();
    wait_grants(3);
    bus.req_valid = '0;
    for (int i = 0; i < 3; i++) chk("rr_order_1_3", glog[base+i], e2[i]);
    repeat (4) @(posedge clk); #1;

    // Backpressure while others wait
    bus.rsp_ready = 1'b0;
    issue(0, ALU_SUB, 32'd5, 32'd7, 1'b0, 1'b0);
    set_req(1, ALU_OR, 32'h0F, 32'hF0, 1'b0, 1'b0);
    set_req(2, ALU_XOR, 32'hFF, 32'h0F, 1'b0, 1'b0);
    wait_rsp_valid("bp_rsp_timeout");
    for (int k = 0; k < 5; k++) begin
      chk("bp_rsp_valid", bus.rsp_valid, 1);
      chk("bp_req_ready", bus.req_ready, 0);
      chk("bp_data", bus.rsp_data, 32'hFFFF_FFFE);
      chk("bp_carry", bus.rsp_carry, 0);
      chk("bp_zero", bus.rsp_zero, 0);
      @(negedge clk);
    end
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    h = cyc;
    base = glog.size();
    wait_grants(1);
    bus.req_valid[1] = 1'b0;
    chk("bp_resume_cycle", gcyc[base], h + 1);
    chk("bp_resume_id", glog[base], 1);
    wait_grants(1);
    bus.req_valid[2] = 1'b0;
    chk("bp_next_id", glog[base+1], 2);
    repeat (4) @(posedge clk); #1;

    // Carry chaining with an interleaved requester
    issue(2, ALU_ADD, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
    issue(1, ALU_ADD, 32'd3, 32'd4, 1'b0, 1'b0);
    issue(2, ALU_ADD, 32'h0, 32'h0, 1'b0, 1'b1);
    repeat (4) @(posedge clk); #1;
    n = rlog.size();
    chk("chain_lo_data", rlog[n-3].data, 32'h0);
    chk("chain_lo_carry", rlog[n-3].carry, 1);
    chk("chain_mid_id", rlog[n-2].id, 1);
    chk("chain_mid_data", rlog[n-2].data, 32'd7);
    chk("chain_hi_id", rlog[n-1].id, 2);
    chk("chain_hi_data", rlog[n-1].data, CHAIN_EXP);

    // Shifts and logic ops
    issue(3, ALU_SHCL, 32'h8000_0001, 32'h0, 1'b1, 1'b0);
    issue(3, ALU_SHCR, 32'h8000_0001, 32'h0, 1'b0, 1'b0);
    issue(0, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 1'b1, 1'b0);
    issue(1, ALU_XOR, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0);
    issue(2, ALU_NOT, 32'h0, 32'h0, 1'b0, 1'b0);
    repeat (4) @(posedge clk); #1;
    n = rlog.size();
    chk("shcl_data", rlog[n-5].data, 32'h0000_0003);
    chk("shcl_carry", rlog[n-5].carry, 1);
    chk("shcr_data", rlog[n-4].data, 32'h4000_0000);
    chk("shcr_carry", rlog[n-4].carry, 1);
    chk("and_data", rlog[n-3].data, 32'h0000_F000);
    chk("and_carry", rlog[n-3].carry, 1);
    chk("xor_zero", rlog[n-2].zero, 1);
    chk("not_data", rlog[n-1].data, 32'hFFFF_FFFF);

    // Reset while in EXEC drops the operation and restarts the pointer
    issue(1, ALU_ADD, 32'd1, 32'd2, 1'b0, 1'b0);
    reset = 1'b1; @(posedge clk); #1 reset = 1'b0;
    n = rlog.size();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rst_exec_no_rsp", bus.rsp_valid, 0);
      chk("rst_exec_data", bus.rsp_data, 0);
    end
    @(posedge clk); #1;
    chk("rst_exec_dropped", rlog.size(), n);
    set_req(0, ALU_ADD, 32'd10, 32'd20, 1'b0, 1'b0);
    set_req(3, ALU_SUB, 32'd9, 32'd4, 1'b0, 1'b0);
    base = glog.size();
    wait_grants(1);
    bus.req_valid[0] = 1'b0;
    wait_grants(1);
    bus.req_valid[3] = 1'b0;
    chk("rst_ptr_first", glog[base], 0);
    chk("rst_ptr_second", glog[base+1], 3);
    repeat (4) @(posedge clk); #1;
    n = rlog.size();
    chk("rst_req3_id", rlog[n-1].id, 3);
    chk("rst_req3_data", rlog[n-1].data, 32'd5);
    chk("rst_req3_carry", rlog[n-1].carry, 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
